fifo_rr_scheduler: RTL and testbench



---
 rtl/fifo_sched_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/fifo_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types for the FIFO round-robin read scheduler.
package fifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping mod N.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl       = {req_i, req_i};
        mask      = {(2*N){1'b1}} << ptr_i;
        masked    = dbl & mask;
        gnt_vld_o = |req_i;
        gnt_idx_o = '0;
        // Scan downwards so the lowest masked bit wins; the upper copy supplies the wrap.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_idx_o = IW'(i % int'(N));
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains NUM_CH showahead FIFOs round-robin, in bursts of up to BURST_LEN words,
// onto a single registered valid/ready stream tagged with the source channel.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned BURST_LEN = 8,
    localparam int unsigned CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic [NUM_CH-1:0]        ch_empty_i,
    input  logic [NUM_CH*DWIDTH-1:0] ch_q_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    output logic [NUM_CH-1:0]        ch_rdreq_o,
    output logic [DWIDTH-1:0]        data_o,
    output logic [CH_W-1:0]          ch_id_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    sched_state_t      state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;

    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_vld;
    logic              gnt_ok;
    logic              can_pop;
    logic              pop;
    logic [DWIDTH-1:0] gnt_data;

    assign eligible = ch_en_i & ~ch_empty_i;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_rr_arbiter (
        .req_i     (eligible),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    assign gnt_ok   = ch_en_i[gnt_q] & ~ch_empty_i[gnt_q];
    assign can_pop  = ~valid_q | ready_i;
    // Gating with reset keeps rdreq low combinationally while reset is held.
    assign pop      = (state_q == GRANT) & can_pop & gnt_ok & srst_n_i;
    assign gnt_data = ch_q_i[int'(gnt_q)*DWIDTH +: DWIDTH];

    always_comb begin
        ch_rdreq_o = '0;
        if (pop) begin
            ch_rdreq_o[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        ch_id_d     = ch_id_q;

        if (pop) begin
            data_d  = gnt_data;
            ch_id_d = gnt_q;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d       = arb_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // An empty or disabled channel ends the grant even while the output stalls.
                if ((pop && (burst_cnt_q == LAST_CNT)) || !gnt_ok) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == LAST_CH) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ch_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ch_id_q     <= ch_id_d;
        end
    end

    assign data_o  = data_q;
    assign ch_id_o = ch_id_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with behavioural showahead FIFOs and an accept monitor.
module tb_fifo_rr_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned BL  = 2;

    logic               clk_i = 1'b0;
    logic               srst_n_i;
    logic [NCH-1:0]     ch_empty_r;
    logic [NCH*DW-1:0]  ch_q_r;
    logic [NCH-1:0]     ch_en_i;
    logic [NCH-1:0]     ch_rdreq_o;
    logic [DW-1:0]      data_o;
    logic [1:0]         ch_id_o;
    logic               valid_o;
    logic               ready_i;
    logic               busy_o;

    logic [DW-1:0]      fq [NCH][$];
    logic [DW+1:0]      rx_q [$];
    int                 rx_cyc [$];
    int                 cyc = 0;
    bit                 bad_pop = 1'b0;
    int                 n_chk = 0;
    int                 n_pass = 0;
    int                 n_fail = 0;

    always #5 clk_i = ~clk_i;

    fifo_rr_scheduler #(
        .NUM_CH    (NCH),
        .DWIDTH    (DW),
        .BURST_LEN (BL)
    ) u_dut (
        .clk_i      (clk_i),
        .srst_n_i   (srst_n_i),
        .ch_empty_i (ch_empty_r),
        .ch_q_i     (ch_q_r),
        .ch_en_i    (ch_en_i),
        .ch_rdreq_o (ch_rdreq_o),
        .data_o     (data_o),
        .ch_id_o    (ch_id_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o)
    );

    // Showahead FIFO models: empty/q are registered and reflect pops from the previous edge.
    always @(posedge clk_i) begin
        cyc++;
        if ($countones(ch_rdreq_o) > 1) bad_pop = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (ch_rdreq_o[k] === 1'b1) begin
                if (fq[k].size() == 0) bad_pop = 1'b1;
                else void'(fq[k].pop_front());
            end
        end
        for (int k = 0; k < NCH; k++) begin
            ch_empty_r[k]        <= (fq[k].size() == 0);
            ch_q_r[k*DW +: DW]   <= (fq[k].size() != 0) ? fq[k][0] : '0;
        end
    end

    always @(negedge clk_i) begin
        if (srst_n_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            rx_q.push_back({ch_id_o, data_o});
            rx_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW+1:0] ent(input int ch, input int d);
        return {2'(ch), 32'(d)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        srst_n_i = 1'b0;
        ready_i  = 1'b1;
        ch_en_i  = '1;
        for (int k = 0; k < NCH; k++) fq[k].delete();
        step(2);
        srst_n_i = 1'b1;
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic wait_valid(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        bit found;
        srst_n_i   = 1'b0;
        ready_i    = 1'b1;
        ch_en_i    = '1;

        // Reset with all FIFOs empty: nothing moves for 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("idle_valid", 64'(valid_o), 64'd0);
            check("idle_rdreq", 64'(ch_rdreq_o), 64'd0);
            check("idle_busy", 64'(busy_o), 64'd0);
        end
        step(1);

        // Four channels x 3 words, burst of 2.
        do_reset();
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < 3; i++) fq[k].push_back(32'(k*16 + i));
        step(40);
        check("rr_count", 64'(rx_q.size()), 64'd12);
        for (int k = 0; k < NCH; k++) begin
            check("rr_round1_a", 64'(rx_q[2*k]), 64'(ent(k, k*16)));
            check("rr_round1_b", 64'(rx_q[2*k+1]), 64'(ent(k, k*16 + 1)));
            check("rr_round2", 64'(rx_q[8+k]), 64'(ent(k, k*16 + 2)));
        end
        for (int j = 1; j < 8; j++)
            check("rr_bubble", 64'(rx_cyc[j] - rx_cyc[j-1]), (j % 2 == 1) ? 64'd1 : 64'd2);

        // Channel 2 alone, 5 words.
        do_reset();
        for (int i = 0; i < 5; i++) fq[2].push_back(32'(32 + i));
        step(30);
        check("solo_count", 64'(rx_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) check("solo_word", 64'(rx_q[i]), 64'(ent(2, 32 + i)));
        @(negedge clk_i);
        check("solo_ptr", 64'(u_dut.rr_ptr_q), 64'd3);
        check("solo_busy", 64'(busy_o), 64'd0);

        // Output stall for 4 cycles mid-burst.
        do_reset();
        for (int i = 0; i < 4; i++) fq[0].push_back(32'hA0 + 32'(i));
        wait_valid("stall_first_valid");
        step(1);
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("stall_data", 64'(data_o), 64'hA1);
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_rdreq", 64'(ch_rdreq_o), 64'd0);
        end
        step(1);
        ready_i = 1'b1;
        step(20);
        check("stall_count", 64'(rx_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("stall_word", 64'(rx_q[i]), 64'(ent(0, 32'hA0 + i)));

        // Disable channel 1 mid-burst, re-enable later.
        do_reset();
        for (int i = 0; i < 4; i++) fq[1].push_back(32'(16 + i));
        fq[2].push_back(32'h20);
        fq[2].push_back(32'h21);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (ch_rdreq_o[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("en_first_pop", 64'(found), 64'd1);
        step(1);
        ch_en_i[1] = 1'b0;
        step(15);
        check("en_partial_count", 64'(rx_q.size()), 64'd3);
        ch_en_i[1] = 1'b1;
        step(20);
        check("en_count", 64'(rx_q.size()), 64'd6);
        check("en_w0", 64'(rx_q[0]), 64'(ent(1, 16)));
        check("en_w1", 64'(rx_q[1]), 64'(ent(2, 32)));
        check("en_w2", 64'(rx_q[2]), 64'(ent(2, 33)));
        for (int i = 1; i < 4; i++) check("en_tail", 64'(rx_q[2+i]), 64'(ent(1, 16 + i)));

        // One-cycle reset mid-burst while a word is pending.
        do_reset();
        for (int i = 0; i < 3; i++) fq[2].push_back(32'(32 + i));
        wait_valid("rst_first_valid");
        step(1);
        srst_n_i = 1'b0;
        ready_i  = 1'b0;
        fq[0].push_back(32'h55);
        @(negedge clk_i);
        check("rst_rdreq", 64'(ch_rdreq_o), 64'd0);
        step(1);
        srst_n_i = 1'b1;
        ready_i  = 1'b1;
        rx_q.delete();
        rx_cyc.delete();
        @(negedge clk_i);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ptr", 64'(u_dut.rr_ptr_q), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        step(15);
        check("rst_count", 64'(rx_q.size()), 64'd2);
        check("rst_w0", 64'(rx_q[0]), 64'(ent(0, 32'h55)));
        check("rst_w1", 64'(rx_q[1]), 64'(ent(2, 34)));

        check("no_bad_rdreq", 64'(bad_pop), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
